ex_wb_buffer: RTL and testbench

EX_WB_BUFFER -- requirements
Module: ex_wb_buffer

---
 rtl/ex_wb_buffer.sv | 128 ++++++++++++
 tb/tb_ex_wb_buffer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_wb_buffer.sv
// EX->WB pipeline buffer: 2-entry skid buffer (head + skid) carrying ALU result, rd, reg_we and result flags.
// Latency: 1 cycle from acceptance to out_* when empty; entries leave strictly in acceptance order.
// Backpressure: in_ready is registered (low only when both entries are held), so out_ready never reaches in_ready combinationally.
module ex_wb_buffer #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_result,
    input  logic [RADDR_W-1:0] in_rd,
    input  logic               in_reg_we,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_result,
    output logic [RADDR_W-1:0] out_rd,
    output logic               out_reg_we,
    output logic               out_zero,
    output logic               out_neg
);

    typedef struct packed {
        logic [DATA_W-1:0]  result;
        logic [RADDR_W-1:0] rd;
        logic               reg_we;
    } entry_t;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0] state;
    logic [1:0] state_nxt;
    entry_t     head;
    entry_t     skid;
    entry_t     in_entry;
    logic       in_xfer;
    logic       out_xfer;
    logic       load_head_in;
    logic       load_head_skid;
    logic       load_skid;

    // Writes to register 0 are dropped at capture so the writeback stage never sees them.
    assign in_entry = {in_result, in_rd, in_reg_we & (in_rd != '0)};

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    // Next-state and register-load selection; flush overrides every transfer.
    always_comb begin
        state_nxt      = state;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (in_xfer) begin
                    state_nxt    = ST_ONE;
                    load_head_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (in_xfer && out_xfer) begin
                    load_head_in = 1'b1;
                end else if (out_xfer) begin
                    state_nxt = ST_EMPTY;
                end else if (in_xfer) begin
                    state_nxt = ST_FULL;
                    load_skid = 1'b1;
                end
            end
            ST_FULL: begin
                if (out_xfer) begin
                    state_nxt      = ST_ONE;
                    load_head_skid = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_EMPTY;
            end
        endcase
        if (flush) begin
            state_nxt      = ST_EMPTY;
            load_head_in   = 1'b0;
            load_head_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    // Occupancy state and registered in_ready (high unless the next state holds two entries).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt != ST_FULL);
        end
    end

    // Entry storage: head is what writeback sees, skid absorbs the one extra entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            skid <= '0;
        end else begin
            if (load_head_in) begin
                head <= in_entry;
            end else if (load_head_skid) begin
                head <= skid;
            end
            if (load_skid) begin
                skid <= in_entry;
            end
        end
    end

    assign out_valid  = (state == ST_ONE) || (state == ST_FULL);
    assign out_result = head.result;
    assign out_rd     = head.rd;
    assign out_reg_we = head.reg_we & out_valid;
    assign out_zero   = (head.result == '0);
    assign out_neg    = head.result[DATA_W-1];

endmodule

// File: tb/tb_ex_wb_buffer.sv
// Self-checking bench for ex_wb_buffer: directed scenarios plus random traffic against a queue model.
// Timing: inputs driven and outputs checked on the falling edge; DUT updates on the rising edge.
// Backpressure: out_ready and flush randomized; the model tracks occupancy as a bounded queue of depth 2.
module tb_ex_wb_buffer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic [4:0]  in_rd;
    logic        in_reg_we;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_reg_we;
    logic        out_zero;
    logic        out_neg;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        we;
    } ent_t;

    ent_t        mq[$];     // reference contents, head at index 0
    logic [31:0] pops[$];   // results observed leaving the DUT
    int          n_cmp;
    int          n_err;

    ex_wb_buffer #(.DATA_W(32), .RADDR_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_rd      (in_rd),
        .in_reg_we  (in_reg_we),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .out_reg_we (out_reg_we),
        .out_zero   (out_zero),
        .out_neg    (out_neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compare every visible output against the model's view of the buffer.
    task automatic check_outputs(input string tag);
        chk({tag, ".in_ready"}, {63'd0, in_ready}, {63'd0, mq.size() < 2});
        chk({tag, ".out_valid"}, {63'd0, out_valid}, {63'd0, mq.size() > 0});
        if (mq.size() > 0) begin
            chk({tag, ".out_result"}, {32'd0, out_result}, {32'd0, mq[0].res});
            chk({tag, ".out_rd"}, {59'd0, out_rd}, {59'd0, mq[0].rd});
            chk({tag, ".out_reg_we"}, {63'd0, out_reg_we}, {63'd0, mq[0].we});
            chk({tag, ".out_zero"}, {63'd0, out_zero}, {63'd0, mq[0].res == 32'd0});
            chk({tag, ".out_neg"}, {63'd0, out_neg}, {63'd0, mq[0].res[31]});
        end else begin
            chk({tag, ".out_reg_we_idle"}, {63'd0, out_reg_we}, 64'd0);
        end
    endtask

    // One clock: drive at falling edge, update model at rising edge, check at next falling edge.
    task automatic step(input string tag, input logic iv, input logic [31:0] res, input logic [4:0] rd,
                        input logic we, input logic ordy, input logic fl);
        bit   m_in;
        bit   m_out;
        bit   d_pop;
        logic [31:0] d_val;
        ent_t e;
        in_valid  = iv;
        in_result = res;
        in_rd     = rd;
        in_reg_we = we;
        out_ready = ordy;
        flush     = fl;
        m_in  = iv && (mq.size() < 2);
        m_out = ordy && (mq.size() > 0);
        #1;
        d_pop = out_valid && out_ready;
        d_val = out_result;
        @(posedge clk);
        if (d_pop && !fl) pops.push_back(d_val);
        if (fl) begin
            mq.delete();
        end else begin
            if (m_out) void'(mq.pop_front());
            if (m_in) begin
                e.res = res;
                e.rd  = rd;
                e.we  = we && (rd != 5'd0);
                mq.push_back(e);
            end
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic idle(input string tag, input logic ordy);
        step(tag, 1'b0, 32'd0, 5'd0, 1'b0, ordy, 1'b0);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_result = 32'd0;
        in_rd     = 5'd0;
        in_reg_we = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;

        // Reset values.
        #12;
        chk("rst.in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst.out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst.out_result", {32'd0, out_result}, 64'd0);
        chk("rst.out_rd", {59'd0, out_rd}, 64'd0);
        chk("rst.out_reg_we", {63'd0, out_reg_we}, 64'd0);
        chk("rst.out_zero", {63'd0, out_zero}, 64'd1);
        chk("rst.out_neg", {63'd0, out_neg}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single push with out_ready high: visible next cycle, gone the one after.
        step("single", 1'b1, 32'h0000_0005, 5'd3, 1'b1, 1'b1, 1'b0);
        chk("single.res", {32'd0, out_result}, 64'h5);
        chk("single.rd", {59'd0, out_rd}, 64'd3);
        chk("single.we", {63'd0, out_reg_we}, 64'd1);
        chk("single.zero", {63'd0, out_zero}, 64'd0);
        idle("single_drain", 1'b1);
        chk("single.gone", {63'd0, out_valid}, 64'd0);

        // Fill with A,B under backpressure, hold C, then release: order 11,22,33.
        pops.delete();
        step("fillA", 1'b1, 32'h11, 5'd1, 1'b1, 1'b0, 1'b0);
        step("fillB", 1'b1, 32'h22, 5'd2, 1'b1, 1'b0, 1'b0);
        chk("full.in_ready", {63'd0, in_ready}, 64'd0);
        step("holdC", 1'b1, 32'h33, 5'd4, 1'b1, 1'b0, 1'b0);
        chk("hold.head", {32'd0, out_result}, 64'h11);
        step("relC1", 1'b1, 32'h33, 5'd4, 1'b1, 1'b1, 1'b0);
        chk("rel1.head", {32'd0, out_result}, 64'h22);
        step("relC2", 1'b1, 32'h33, 5'd4, 1'b1, 1'b1, 1'b0);
        chk("rel2.head", {32'd0, out_result}, 64'h33);
        idle("relC3", 1'b1);
        chk("order.count", 64'(pops.size()), 64'd3);
        if (pops.size() == 3) begin
            chk("order.0", {32'd0, pops[0]}, 64'h11);
            chk("order.1", {32'd0, pops[1]}, 64'h22);
            chk("order.2", {32'd0, pops[2]}, 64'h33);
        end

        // Flag boundaries and register-0 write suppression.
        step("neg", 1'b1, 32'h8000_0000, 5'd7, 1'b1, 1'b1, 1'b0);
        chk("neg.neg", {63'd0, out_neg}, 64'd1);
        chk("neg.zero", {63'd0, out_zero}, 64'd0);
        step("zero", 1'b1, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0);
        chk("zero.zero", {63'd0, out_zero}, 64'd1);
        step("rd0", 1'b1, 32'hDEAD_BEEF, 5'd0, 1'b1, 1'b1, 1'b0);
        chk("rd0.we", {63'd0, out_reg_we}, 64'd0);
        chk("rd0.res", {32'd0, out_result}, 64'hDEAD_BEEF);
        idle("rd0_drain", 1'b1);

        // Flush while full with a valid input: nothing accepted.
        step("flA", 1'b1, 32'hA1, 5'd1, 1'b1, 1'b0, 1'b0);
        step("flB", 1'b1, 32'hB2, 5'd2, 1'b1, 1'b0, 1'b0);
        step("flush", 1'b1, 32'hC3, 5'd3, 1'b1, 1'b1, 1'b1);
        chk("flush.out_valid", {63'd0, out_valid}, 64'd0);
        chk("flush.in_ready", {63'd0, in_ready}, 64'd1);
        idle("flush_after", 1'b1);
        chk("flush.no_entry", {63'd0, out_valid}, 64'd0);

        // Asynchronous reset between edges while full.
        step("arA", 1'b1, 32'h55, 5'd5, 1'b1, 1'b0, 1'b0);
        step("arB", 1'b1, 32'h66, 5'd6, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.out_valid", {63'd0, out_valid}, 64'd0);
        chk("arst.in_ready", {63'd0, in_ready}, 64'd1);
        chk("arst.out_reg_we", {63'd0, out_reg_we}, 64'd0);
        mq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 1'b1, 32'h77, 5'd9, 1'b1, 1'b0, 1'b0);
        chk("post_rst.res", {32'd0, out_result}, 64'h77);
        idle("post_rst_drain", 1'b1);

        // Random traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] r;
            logic [4:0]  d;
            int          sel;
            sel = int'($urandom_range(0, 7));
            if (sel == 0)      r = 32'd0;
            else if (sel == 1) r = 32'h8000_0000 | $urandom;
            else               r = $urandom;
            d = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            step("rand", 1'($urandom_range(0, 1)), r, d, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
